// File: rtl/uart_word_serializer.sv
// Word-to-byte serializer: latches a word on start and hands it to a byte UART one tx_send/tx_done at a time.
// Optional feature: define UART_SER_QUEUE_EN for a one-word pending buffer that allows back-to-back words.
module uart_word_serializer #(
    parameter int WORD_BYTES = 4,
    parameter int MSB_FIRST  = 1,
    parameter int LEN_W      = $clog2(WORD_BYTES) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic [LEN_W-1:0]        len,
    input  logic                    tx_done,
    output logic [7:0]              tx_byte,
    output logic                    tx_send,
    output logic                    busy,
    output logic                    ready,
    output logic                    done
);
    localparam int W = 8 * WORD_BYTES;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t           state, state_next;
    logic [W-1:0]     data_q, data_next;
    logic [LEN_W-1:0] len_q, len_next;
    logic [LEN_W-1:0] cnt_q, cnt_next;
    logic [7:0]       tx_byte_next;
    logic             tx_send_next, done_next, busy_next, ready_next;
    logic             accept, launch;
    logic [W-1:0]     launch_data;
    logic [LEN_W-1:0] launch_len;
`ifdef UART_SER_QUEUE_EN
    logic             pend_valid, pend_valid_next;
    logic [W-1:0]     pend_data, pend_data_next;
    logic [LEN_W-1:0] pend_len, pend_len_next;
`endif

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l == '0 || l > FULL_LEN) ? FULL_LEN : l;
    endfunction

    // Byte k in transmission order; short words therefore use the leading bytes of that order.
    function automatic logic [7:0] pick_byte(input logic [W-1:0] word, input logic [LEN_W-1:0] k);
        logic [W-1:0] shifted;
        int           sh;
        sh      = (MSB_FIRST != 0) ? 8 * (WORD_BYTES - 1 - int'(k)) : 8 * int'(k);
        shifted = word >> sh;
        return shifted[7:0];
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_next   = state;
        data_next    = data_q;
        len_next     = len_q;
        cnt_next     = cnt_q;
        tx_byte_next = tx_byte;
        tx_send_next = 1'b0;
        done_next    = 1'b0;
        accept       = start && ready;
        launch       = 1'b0;
        launch_data  = tx_data;
        launch_len   = clamp_len(len);
`ifdef UART_SER_QUEUE_EN
        pend_valid_next = pend_valid;
        pend_data_next  = pend_data;
        pend_len_next   = pend_len;
`endif

        unique case (state)
            IDLE: launch = accept;
            SEND: state_next = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (cnt_q + LEN_W'(1) < len_q) begin
                        cnt_next     = cnt_q + LEN_W'(1);
                        state_next   = SEND;
                        tx_send_next = 1'b1;
                        tx_byte_next = pick_byte(data_q, cnt_q + LEN_W'(1));
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
`ifdef UART_SER_QUEUE_EN
                        // Chain straight into the next word so done and its first SEND share a cycle.
                        if (pend_valid) begin
                            launch          = 1'b1;
                            launch_data     = pend_data;
                            launch_len      = pend_len;
                            pend_valid_next = 1'b0;
                        end else begin
                            launch = accept;
                        end
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef UART_SER_QUEUE_EN
        if (accept && state != IDLE && !launch) begin
            pend_valid_next = 1'b1;
            pend_data_next  = tx_data;
            pend_len_next   = clamp_len(len);
        end
`endif

        if (launch) begin
            state_next   = SEND;
            data_next    = launch_data;
            len_next     = launch_len;
            cnt_next     = '0;
            tx_send_next = 1'b1;
            tx_byte_next = pick_byte(launch_data, '0);
        end

        busy_next = (state_next != IDLE);
`ifdef UART_SER_QUEUE_EN
        ready_next = !pend_valid_next;
`else
        ready_next = !busy_next;
`endif
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            tx_byte <= 8'h00;
            tx_send <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
`ifdef UART_SER_QUEUE_EN
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_len   <= '0;
`endif
        end else begin
            state   <= state_next;
            data_q  <= data_next;
            len_q   <= len_next;
            cnt_q   <= cnt_next;
            tx_byte <= tx_byte_next;
            tx_send <= tx_send_next;
            busy    <= busy_next;
            done    <= done_next;
            ready   <= ready_next;
`ifdef UART_SER_QUEUE_EN
            pend_valid <= pend_valid_next;
            pend_data  <= pend_data_next;
            pend_len   <= pend_len_next;
`endif
        end
    end
endmodule

// File: tb/tb_uart_word_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers share one stimulus stream and UART model;
// a word-level reference model predicts every tx_send byte/cycle and every done pulse.
module tb_uart_word_serializer;
`ifdef UART_SER_QUEUE_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {int cyc; logic [7:0] bm; logic [7:0] bl;} send_t;
    typedef struct {int cyc; bit busy;} done_t;
    typedef struct {logic [31:0] data; int len; int ndone;} word_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, tx_done = 1'b0;
    logic [31:0] tx_data = '0;
    logic [2:0]  len = '0;
    logic [7:0]  tx_byte_m, tx_byte_l;
    logic        tx_send_m, busy_m, ready_m, done_m;
    logic        tx_send_l, busy_l, ready_l, done_l;

    logic        s1_start = 1'b0, s1_txd = 1'b0;
    logic [7:0]  s1_data = '0;
    logic [0:0]  s1_len = '0;
    logic [7:0]  o1_byte;
    logic        o1_send, o1_busy, o1_ready, o1_done;

    int cyc = 0;
    int n_checks = 0, n_fail = 0;
    int n_pushed = 0, n_matched = 0, sends_seen = 0;
    int exp_reset_cyc = -5;
    int uart_due = -1, fixed_t = 5, inj_pct = 0;
    bit rand_t = 1'b0;

    word_t words[$];
    send_t exp_send[$];
    done_t exp_done[$];

    uart_word_serializer #(.WORD_BYTES(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .len(len), .tx_done(tx_done),
        .tx_byte(tx_byte_m), .tx_send(tx_send_m), .busy(busy_m), .ready(ready_m), .done(done_m));

    uart_word_serializer #(.WORD_BYTES(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .len(len), .tx_done(tx_done),
        .tx_byte(tx_byte_l), .tx_send(tx_send_l), .busy(busy_l), .ready(ready_l), .done(done_l));

    uart_word_serializer #(.WORD_BYTES(1)) dut_one (
        .clk(clk), .rst(rst), .start(s1_start), .tx_data(s1_data), .len(s1_len), .tx_done(s1_txd),
        .tx_byte(o1_byte), .tx_send(o1_send), .busy(o1_busy), .ready(o1_ready), .done(o1_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte k of a word in transmission order, straight from the byte-order rule.
    function automatic logic [7:0] nth_byte(input logic [31:0] d, input int k, input bit msb);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        return msb ? b[3-k] : b[k];
    endfunction

    task automatic push_send(input word_t w, input int k);
        exp_send.push_back('{cyc: cyc + 1, bm: nth_byte(w.data, k, 1'b1), bl: nth_byte(w.data, k, 1'b0)});
        n_pushed++;
    endtask

    // One clock of stimulus: UART responder, input drive and reference-model update.
    task automatic step(input bit s, input logic [31:0] d, input logic [2:0] l, input bit r);
        int    pre;
        bit    word_end;
        word_t w;
        @(negedge clk);
        pre      = words.size();
        word_end = 1'b0;
        tx_done  = 1'b0;
        rst      = r;
        start    = s && !r;
        tx_data  = d;
        len      = l;
        if (r) begin
            words.delete();
            uart_due      = -1;
            exp_reset_cyc = cyc + 1;
            return;
        end
        if (tx_send_m) begin
            uart_due = cyc + (rand_t ? int'($urandom_range(1, 4)) : fixed_t);
            sends_seen++;
        end
        if (uart_due == cyc && words.size() > 0) begin
            tx_done  = 1'b1;
            uart_due = -1;
            words[0].ndone = words[0].ndone + 1;
            if (words[0].ndone == words[0].len) begin
                void'(words.pop_front());
                word_end = 1'b1;
                if (words.size() > 0) push_send(words[0], 0);
            end else begin
                push_send(words[0], words[0].ndone);
            end
        end else if (int'($urandom_range(0, 99)) < inj_pct && (tx_send_m || words.size() == 0)) begin
            tx_done = 1'b1;
        end
        if (s && pre < CAP) begin
            w.data  = d;
            w.len   = (l == 3'd0 || l > 3'd4) ? 4 : int'(l);
            w.ndone = 0;
            words.push_back(w);
            if (words.size() == 1) push_send(w, 0);
        end
        if (word_end) exp_done.push_back('{cyc: cyc + 1, busy: words.size() > 0});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (words.size() > 0 && n < 2000) begin
            step(1'b0, '0, '0, 1'b0);
            n++;
        end
        check("drain within cycle budget", 32'(words.size()), 32'd0);
        idle(3);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc == exp_reset_cyc) begin
                check("reset tx_byte", {16'h0, tx_byte_l, tx_byte_m}, 32'd0);
                check("reset flags", 32'({busy_l, busy_m, done_l, done_m, tx_send_l, tx_send_m, ready_l, ready_m}),
                      32'h03);
            end
            if (exp_send.size() > 0 && exp_send[0].cyc == cyc) begin
                check("tx_send pulse", 32'({tx_send_l, tx_send_m}), 32'd3);
                check("tx_byte msb-first", 32'(tx_byte_m), 32'(exp_send[0].bm));
                check("tx_byte lsb-first", 32'(tx_byte_l), 32'(exp_send[0].bl));
                void'(exp_send.pop_front());
                n_matched++;
            end else if (tx_send_m || tx_send_l) begin
                check("unexpected tx_send", 32'({tx_send_l, tx_send_m}), 32'd0);
            end
            if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
                check("done pulse", 32'({done_l, done_m}), 32'd3);
                check("busy at done", 32'({busy_l, busy_m}), exp_done[0].busy ? 32'd3 : 32'd0);
                check("ready at done", 32'({ready_l, ready_m}), 32'd3);
                void'(exp_done.pop_front());
            end else if (done_m || done_l) begin
                check("unexpected done", 32'({done_l, done_m}), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        idle(2);

        step(1'b1, 32'hA1B2C3D4, 3'd4, 1'b0);
        drain();
        step(1'b1, 32'hA1B2C3D4, 3'd2, 1'b0);
        drain();

        inj_pct = 50;
        step(1'b1, 32'h0BADBEEF, 3'd0, 1'b0);
        drain();
        step(1'b1, 32'h12345678, 3'd7, 1'b0);
        drain();
        inj_pct = 0;

        step(1'b1, 32'hA1B2C3D4, 3'd4, 1'b0);
        idle(3);
        step(1'b1, 32'h11223344, 3'd4, 1'b0);
        drain();

        sends_seen = 0;
        step(1'b1, 32'h55667788, 3'd4, 1'b0);
        for (int n = 0; n < 100 && sends_seen < 2; n++) step(1'b0, '0, '0, 1'b0);
        check("second tx_send before reset", 32'(sends_seen), 32'd2);
        step(1'b0, '0, '0, 1'b1);
        idle(12);
        step(1'b1, 32'hCAFEF00D, 3'd4, 1'b0);
        drain();

        rand_t  = 1'b1;
        inj_pct = 20;
        repeat (500) step($urandom_range(0, 3) == 0, $urandom, 3'($urandom_range(0, 7)), 1'b0);
        drain();
        inj_pct = 0;

        @(negedge clk);
        s1_start = 1'b1; s1_data = 8'h5A; s1_len = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        check("w1 tx_send", 32'(o1_send), 32'd1);
        check("w1 tx_byte", 32'(o1_byte), 32'h5A);
        @(negedge clk);
        s1_txd = 1'b1;
        @(negedge clk);
        s1_txd = 1'b0;
        check("w1 done", 32'(o1_done), 32'd1);
        check("w1 busy/ready at done", 32'({o1_busy, o1_ready}), 32'd1);
        s1_start = 1'b1; s1_data = 8'hC3; s1_len = 1'b0;
        @(negedge clk);
        s1_start = 1'b0;
        check("w1 back-to-back tx_send", 32'({o1_send, o1_done}), 32'd2);
        check("w1 back-to-back tx_byte", 32'(o1_byte), 32'hC3);
        @(negedge clk);
        s1_txd = 1'b1;
        @(negedge clk);
        s1_txd = 1'b0;
        check("w1 second done", 32'(o1_done), 32'd1);
        @(negedge clk);

        check("all expected sends observed", 32'(n_matched), 32'(n_pushed));
        check("no outstanding done", 32'(exp_done.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
